sram_rw_port_adapter: RTL and testbench
=======================================

# sram_rw_port_adapter

Request/response front end for the single-port behavioural SRAM macros (`RW0_*` port style: registered address, one-cycle read data, per-byte write mask). Converts a valid/ready request stream into `RW0` control signals. Captures read data in the one cycle it is guaranteed valid and returns it on a valid/ready response stream through a 2-entry buffer, so a stalled consumer never loses data. Sits between a cache/scratchpad controller and a data- or tag-array macro.

## Interface
- `ADDR_BITS`, 9: SRAM word-address width.
- `DATA_BITS`, 64: SRAM word width.
- `MASK_BITS`, 8: write-mask width; `DATA_BITS` is a multiple of `MASK_BITS`, and each lane is `DATA_BITS/MASK_BITS` bits.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_BITS  word address.
- `req_wdata`  in  DATA_BITS  write data.
- `req_wmask`  in  MASK_BITS  per-lane write enable.
- `resp_valid`  out  1  read data available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_data`  out  DATA_BITS  read data.
- `sram_en`, `sram_wmode`  out  1 each  to `RW0_en`, `RW0_wmode`.
- `sram_addr`  out  ADDR_BITS  to `RW0_addr`.
- `sram_wmask`  out  MASK_BITS  to `RW0_wmask`.
- `sram_wdata`  out  DATA_BITS  to `RW0_wdata`.
- `sram_rdata`  in  DATA_BITS  from `RW0_rdata`.
- `stat_reads`, `stat_writes`, `stat_stalls`  out  32 each  event counters. Present only with `SRAM_ADAPTER_STATS_EN`.

## Operation
- Issue path is combinational from the request:
  - `sram_en` = `req_valid && req_ready`.
  - `sram_wmode` = `req_write`.
  - `sram_addr`, `sram_wdata` and `sram_wmask` pass through from `req_*`.
  - `sram_wmask` is forced to 0 on reads.
- Writes produce no response. `req_ready` is 1 for writes whenever not in reset.
- Reads are gated by credits:
  - `inflight` is a 1-bit register set when a read is accepted. It marks that `sram_rdata` is valid in the next cycle.
  - `occ` (0..2) is the buffer occupancy.
  - For reads, `req_ready` = `(occ + inflight) < 2`. It is a function of registers only, with no path from `resp_ready`.
- Response selection:
  - If `occ > 0`, `resp_valid` = 1 and `resp_data` = head entry.
  - Else if `inflight`, `resp_valid` = 1 and `resp_data` = `sram_rdata` (flow-through).
  - Else `resp_valid` = 0 and `resp_data` = 0.
- Capture rule in the cycle `inflight` is 1:
  - `sram_rdata` is enqueued at the tail unless it is flow-through and `resp_ready` is 1.
  - A flow-through word that is not taken is enqueued as the head.
- Buffer behaviour:
  - The buffer is a 2-entry circular FIFO with a 1-bit head pointer and a 1-bit tail pointer; both wrap 1→0.
  - Simultaneous enqueue and dequeue leaves `occ` unchanged.
  - Overflow is impossible by construction of the credit rule. The bench asserts `occ` never exceeds 2.
- Ordering: responses return in read-issue order. Intervening writes do not reorder or corrupt captured data.
- Reset:
  - Clears `occ`, both pointers, `inflight` and the counters.
  - A read issued in the cycle before reset asserts is discarded. Its data never appears on `resp_*`.

## Timing
- Reset values:
  - `req_ready` = 0 during reset; both read and write are blocked.
  - `resp_valid` = 0 and `resp_data` = 0.
  - `sram_en` = 0, forced low during reset.
  - Counters = 0.
- Read latency: request accepted at cycle t gives `resp_valid` at t+1 (flow-through). Latency is t+1 only when the buffer is empty at t+1.
- Throughput:
  - One read per cycle is sustained while `resp_ready` stays high.
  - With `resp_ready` low, at most 2 reads are outstanding and `req_ready` drops for reads.
  - Once the consumer drains one entry, `req_ready` for reads returns the following cycle.
- Write and read issue share the single SRAM port, one operation per cycle.
- Buffer contents are never returned with a bubble: a held entry is presented from the cycle after its capture.

## Configuration
- `SRAM_ADAPTER_STATS_EN` defined: adds the three 32-bit counters, each wrapping at 2^32.
  - `stat_reads` increments on each accepted read.
  - `stat_writes` increments on each accepted write.
  - `stat_stalls` increments on each cycle with `req_valid && !req_ready`.
- Not defined: the counters and their ports are absent. Datapath behaviour is identical with or without the macro.

## Test plan
- **Write then read:** write addr 5, data 0x1122334455667788, mask 0xFF. Read addr 5 at t → `resp_valid` at t+1 with 0x1122334455667788.
- **Partial mask:** write 0xFFFF…FF with mask 0x0F over 0 at addr 7 → read returns 0x00000000FFFFFFFF.
- **Back-pressure:** `resp_ready` = 0, reads to addrs 1, 2, 3 back-to-back → only 1 and 2 accepted, `req_ready` low. Raise `resp_ready` → data for 1, then 2, in order; the read of 3 is then accepted.
- **Streaming:** 16 consecutive reads with `resp_ready` = 1 → 16 responses on consecutive cycles, `req_ready` never low, `occ` stays 0.
- **Reset mid-flight:** accept a read, assert reset the next cycle → `resp_valid` stays 0 and `occ` = 0. After reset, the first read returns only its own data.
- **Stats (macro on):** 3 reads, 2 writes, 4 stall cycles → counters read 3 / 2 / 4. Reset → all counters 0.

Source files
------------

// File: rtl/sram_rw_port_adapter.sv
// rtl/sram_rw_port_adapter.sv - valid/ready front end for a single-port RW0 SRAM macro
// Optional event counters: define SRAM_ADAPTER_STATS_EN.
module sram_rw_port_adapter #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 64,
    parameter int MASK_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    input  logic [MASK_BITS-1:0] req_wmask,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_data,
    output logic                 sram_en,
    output logic                 sram_wmode,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [MASK_BITS-1:0] sram_wmask,
    output logic [DATA_BITS-1:0] sram_wdata,
    input  logic [DATA_BITS-1:0] sram_rdata
`ifdef SRAM_ADAPTER_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_writes,
    output logic [31:0]          stat_stalls
`endif
);

    logic [1:0]           occ_q, occ_d;
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic                 inflight_q, inflight_d;
    logic [DATA_BITS-1:0] fifo_q [2];
    logic [DATA_BITS-1:0] fifo_d [2];

    logic credit_ok;
    logic rd_accept;
    logic wr_accept;
    logic flow_taken;
    logic enq;
    logic deq;

    // Read credits depend on registers only, so req_ready has no path from resp_ready.
    always_comb begin
        credit_ok  = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
        req_ready  = !reset && (req_write || credit_ok);
        sram_en    = req_valid && req_ready;
        sram_wmode = req_write;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
        sram_wmask = req_write ? req_wmask : '0;
        rd_accept  = sram_en && !req_write;
        wr_accept  = sram_en && req_write;
    end

    always_comb begin
        resp_valid = !reset && ((occ_q != 2'd0) || inflight_q);
        resp_data  = '0;
        if (resp_valid) begin
            resp_data = (occ_q != 2'd0) ? fifo_q[head_q] : sram_rdata;
        end
    end

    // sram_rdata is only valid while inflight_q is set; park it unless it leaves as flow-through.
    always_comb begin
        flow_taken = inflight_q && (occ_q == 2'd0) && resp_ready;
        enq        = inflight_q && !flow_taken;
        deq        = (occ_q != 2'd0) && resp_ready;
        occ_d      = occ_q + {1'b0, enq} - {1'b0, deq};
        head_d     = head_q ^ deq;
        tail_d     = tail_q ^ enq;
        inflight_d = rd_accept;
        fifo_d     = fifo_q;
        if (enq) begin
            fifo_d[tail_q] = sram_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

`ifdef SRAM_ADAPTER_STATS_EN
    logic [31:0] stat_reads_q,  stat_reads_d;
    logic [31:0] stat_writes_q, stat_writes_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_reads_d  = stat_reads_q  + {31'd0, rd_accept};
        stat_writes_d = stat_writes_q + {31'd0, wr_accept};
        stat_stalls_d = stat_stalls_q + {31'd0, req_valid && !req_ready};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_reads_q  <= 32'd0;
            stat_writes_q <= 32'd0;
            stat_stalls_q <= 32'd0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_sram_rw_port_adapter.sv
// tb/tb_sram_rw_port_adapter.sv - directed self-checking bench for sram_rw_port_adapter
module tb_sram_rw_port_adapter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        sram_en;
    logic        sram_wmode;
    logic [8:0]  sram_addr;
    logic [7:0]  sram_wmask;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata = 64'd0;
`ifdef SRAM_ADAPTER_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_stalls;
`endif

    int checks = 0;
    int errors = 0;
    logic occ_over = 1'b0;
    logic [63:0] mem [512];

    localparam logic [63:0] D1 = 64'h1111_0000_0000_0001;
    localparam logic [63:0] D2 = 64'h2222_0000_0000_0002;
    localparam logic [63:0] D3 = 64'h3333_0000_0000_0003;
    localparam logic [63:0] DW = 64'h1122_3344_5566_7788;
    localparam logic [63:0] DP = 64'h0000_0000_FFFF_FFFF;

    always #5 clock = ~clock;

    sram_rw_port_adapter dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
`ifdef SRAM_ADAPTER_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes),
        .stat_stalls(stat_stalls)
`endif
    );

    // Behavioural RW0 macro: registered read, read data only meaningful for one cycle.
    always @(posedge clock) begin
        if (sram_en && sram_wmode) begin
            for (int l = 0; l < 8; l++) begin
                if (sram_wmask[l]) mem[sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
            end
        end
        if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
        else                        sram_rdata <= {$urandom, $urandom};
    end

    always @(negedge clock) begin
        if (dut.occ_q > 2'd2) occ_over <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [8:0] a,
                         input logic [63:0] d, input logic [7:0] m, input logic rr);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_wmask  = m;
        resp_ready = rr;
        #1;
    endtask

    function automatic logic [63:0] sdata(input int i);
        return 64'h0123_4567_0000_0000 | 64'(i * 3 + 1);
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'd0;
        reset = 1'b1;
        drive(1'b1, 1'b1, 9'd0, 64'd0, 8'hFF, 1'b1);
        tick();
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_sram_en", {63'd0, sram_en}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
`ifdef SRAM_ADAPTER_STATS_EN
        check("rst_stat_reads", {32'd0, stat_reads}, 64'd0);
`endif
        tick();
        reset = 1'b0;

        // write then read
        drive(1'b1, 1'b1, 9'd5, DW, 8'hFF, 1'b1);
        check("wr_ready", {63'd0, req_ready}, 64'd1);
        check("wr_en", {63'd0, sram_en}, 64'd1);
        check("wr_mask", {56'd0, sram_wmask}, 64'hFF);
        tick();
        drive(1'b1, 1'b0, 9'd5, 64'd0, 8'hFF, 1'b1);
        check("rd_ready", {63'd0, req_ready}, 64'd1);
        check("rd_mask_forced", {56'd0, sram_wmask}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1);
        check("rd_lat_valid", {63'd0, resp_valid}, 64'd1);
        check("rd_lat_data", resp_data, DW);
        tick();
        check("rd_done_valid", {63'd0, resp_valid}, 64'd0);

        // partial mask
        drive(1'b1, 1'b1, 9'd7, 64'd0, 8'hFF, 1'b1);
        tick();
        drive(1'b1, 1'b1, 9'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
        check("pm_mask", {56'd0, sram_wmask}, 64'h0F);
        tick();
        drive(1'b1, 1'b0, 9'd7, 64'd0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1);
        check("pm_data", resp_data, DP);
        tick();

        // back-pressure with an intervening write
        drive(1'b1, 1'b1, 9'd1, D1, 8'hFF, 1'b1); tick();
        drive(1'b1, 1'b1, 9'd2, D2, 8'hFF, 1'b1); tick();
        drive(1'b1, 1'b1, 9'd3, D3, 8'hFF, 1'b1); tick();
        drive(1'b1, 1'b0, 9'd1, 64'd0, 8'h00, 1'b0);
        check("bp_rd1_ready", {63'd0, req_ready}, 64'd1);
        tick();
        drive(1'b1, 1'b0, 9'd2, 64'd0, 8'h00, 1'b0);
        check("bp_rd2_ready", {63'd0, req_ready}, 64'd1);
        check("bp_flow_d1", resp_data, D1);
        tick();
        drive(1'b1, 1'b0, 9'd3, 64'd0, 8'h00, 1'b0);
        check("bp_rd3_blocked", {63'd0, req_ready}, 64'd0);
        check("bp_rd3_no_en", {63'd0, sram_en}, 64'd0);
        check("bp_held_d1", resp_data, D1);
        tick();
        drive(1'b1, 1'b1, 9'd9, 64'hDEAD_BEEF_0000_0009, 8'hFF, 1'b0);
        check("bp_wr_ready", {63'd0, req_ready}, 64'd1);
        check("bp_full_valid", {63'd0, resp_valid}, 64'd1);
        tick();
        drive(1'b1, 1'b0, 9'd3, 64'd0, 8'h00, 1'b1);
        check("bp_full_blocked", {63'd0, req_ready}, 64'd0);
        check("bp_order_d1", resp_data, D1);
        tick();
        drive(1'b1, 1'b0, 9'd3, 64'd0, 8'h00, 1'b1);
        check("bp_ready_back", {63'd0, req_ready}, 64'd1);
        check("bp_order_d2", resp_data, D2);
        tick();
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1);
        check("bp_order_d3", resp_data, D3);
        check("bp_d3_valid", {63'd0, resp_valid}, 64'd1);
        tick();
        check("bp_empty", {63'd0, resp_valid}, 64'd0);
        drive(1'b1, 1'b0, 9'd9, 64'd0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1);
        check("bp_wr_intact", resp_data, 64'hDEAD_BEEF_0000_0009);
        tick();

        // streaming
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 9'(16 + i), sdata(i), 8'hFF, 1'b1);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 9'(16 + i), 64'd0, 8'h00, 1'b1);
            check("st_ready", {63'd0, req_ready}, 64'd1);
            check("st_occ", {62'd0, dut.occ_q}, 64'd0);
            if (i > 0) begin
                check("st_valid", {63'd0, resp_valid}, 64'd1);
                check("st_data", resp_data, sdata(i - 1));
            end
            tick();
        end
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1);
        check("st_last", resp_data, sdata(15));
        tick();

        // reset mid-flight
        drive(1'b1, 1'b0, 9'd5, 64'd0, 8'h00, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b0);
        check("rmf_in_reset", {63'd0, resp_valid}, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rmf_after_valid", {63'd0, resp_valid}, 64'd0);
        check("rmf_after_occ", {62'd0, dut.occ_q}, 64'd0);
        drive(1'b1, 1'b0, 9'd7, 64'd0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1);
        check("rmf_own_data", resp_data, DP);
        tick();
        check("rmf_single", {63'd0, resp_valid}, 64'd0);

`ifdef SRAM_ADAPTER_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 9'd1, 64'd0, 8'h00, 1'b0); tick();
        drive(1'b1, 1'b0, 9'd2, 64'd0, 8'h00, 1'b0); tick();
        drive(1'b1, 1'b0, 9'd3, 64'd0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1); tick(); tick();
        drive(1'b1, 1'b0, 9'd1, 64'd0, 8'h00, 1'b1); tick();
        drive(1'b1, 1'b1, 9'd40, 64'd1, 8'hFF, 1'b1); tick();
        drive(1'b1, 1'b1, 9'd41, 64'd2, 8'hFF, 1'b1); tick();
        drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b1); tick();
        check("stat_reads", {32'd0, stat_reads}, 64'd3);
        check("stat_writes", {32'd0, stat_writes}, 64'd2);
        check("stat_stalls", {32'd0, stat_stalls}, 64'd4);
        reset = 1'b1;
        tick();
        check("stat_rst_reads", {32'd0, stat_reads}, 64'd0);
        check("stat_rst_writes", {32'd0, stat_writes}, 64'd0);
        check("stat_rst_stalls", {32'd0, stat_stalls}, 64'd0);
        reset = 1'b0;
        tick();
`endif

        check("occ_never_over_2", {63'd0, occ_over}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
